branch_ctrl: RTL
================

# branch_ctrl

Branch resolution controller for the dynamic pipeline's ID stage. It holds ID while a control-transfer instruction's operands are still in flight. Once they are ready, it samples the branch-decision result and issues a one-cycle PC redirect plus IF squash for taken transfers. It also keeps saturating branch and taken-branch statistics. It sits between the decode/hazard logic, the branch-decision unit and the PC/IF-ID register.

## Interface
Parameters:
- CW, 16, width of the statistics counters
- MAX_WAIT, 8, operand-wait cycle count at which the timeout flag is raised

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  ID stage holds a valid instruction
- id_ctrl  in  1  ID instruction is BEQ/BNE/J/JAL/JR
- opnd_busy  in  1  a source register of the ID instruction is not yet forwardable
- take  in  1  branch-decision result for the ID instruction (combinational from the decision unit)
- target  in  32  resolved target address
- pipe_flush  in  1  exception/global flush; highest priority
- stall_id  out  1  hold PC and IF/ID register (combinational)
- redirect  out  1  load PC with redirect_pc (registered, 1-cycle pulse)
- redirect_pc  out  32  redirect address (registered)
- squash_if  out  1  replace IF/ID contents with a bubble (registered, same cycle as redirect)
- br_count  out  CW  resolved control transfers (saturating)
- taken_count  out  CW  resolved taken transfers (saturating)
- wait_timeout  out  1  sticky: an operand wait reached MAX_WAIT cycles

## Operation
- States:
  - IDLE: no pending transfer
  - WAIT: stalled on operands
  - SQUASH: the cycle after a taken resolution
- req = id_valid & id_ctrl. It is ignored in SQUASH, because the ID instruction in that cycle is wrong-path.
- IDLE transitions:
  - req & opnd_busy -> WAIT, wait_cnt = 1
  - req & !opnd_busy -> resolve
- WAIT transitions:
  - opnd_busy -> stay; wait_cnt increments, saturating at MAX_WAIT
  - !opnd_busy -> resolve
  - !req (ID killed externally) -> IDLE, no resolution
- stall_id = req & opnd_busy & (state != SQUASH) & !pipe_flush.
- Resolve, in the cycle where req & !opnd_busy in IDLE/WAIT. Effects at the next edge:
  - br_count += 1
  - if take: taken_count += 1, redirect = 1, squash_if = 1, redirect_pc = target, state -> SQUASH
  - else: state -> IDLE
- SQUASH: redirect and squash_if are high for exactly this cycle. The next state is IDLE unconditionally.
- Counters saturate at 2^CW-1 and never wrap.
- wait_timeout is set at the edge where wait_cnt reaches MAX_WAIT. It clears only on rst.
- pipe_flush forces the following at the next edge:
  - state -> IDLE
  - redirect and squash_if -> 0
  - wait_cnt -> 0
  - no counter update

  It overrides a resolution in the same cycle, and a pending SQUASH pulse is cancelled.
- redirect_pc holds its last value when redirect = 0.

## Timing
- Reset (rst high at an edge):
  - state IDLE, wait_cnt 0
  - redirect 0, squash_if 0, redirect_pc 0
  - br_count 0, taken_count 0, wait_timeout 0
  - stall_id follows its equation with state IDLE; it is inactive during reset.
- Reset mid-WAIT or mid-SQUASH: all state is discarded and nothing is counted.
- Resolution to redirect latency: 1 cycle. A taken branch resolved in cycle N gives redirect/squash_if high in N+1 and the correct-path fetch in N+2.
- stall_id has 0-cycle latency from opnd_busy and deasserts in the same cycle opnd_busy falls, which is the resolution cycle.
- Back-to-back control instructions:
  - after not-taken, a new req is accepted in the very next cycle
  - after taken, the earliest new resolution is 2 cycles later (SQUASH in between)
- Simultaneous rst and pipe_flush: rst wins; both lead to IDLE.

## Test plan
- Reset, then a BEQ with req=1, opnd_busy=0, take=1, target=0x00400020 -> next cycle redirect=1, squash_if=1, redirect_pc=0x00400020; br_count=1, taken_count=1; following cycle redirect=0.
- BNE with opnd_busy=1 for 3 cycles, then 0, take=0 -> stall_id high for exactly 3 cycles; no redirect; br_count=1, taken_count=0; wait_timeout=0.
- With MAX_WAIT=8, opnd_busy held for 10 cycles -> wait_timeout rises after the 8th wait cycle and stays 1 after the branch resolves; it clears only on rst.
- Taken J in cycle N with pipe_flush=1 in cycle N -> no redirect in N+1; counters unchanged; state IDLE. Repeat with pipe_flush in N+1 (SQUASH) -> redirect still pulses in N+1, since it was already registered, and the state returns to IDLE.
- Two consecutive taken branches with a new req present during SQUASH -> the SQUASH-cycle req is ignored, with no stall or count from it; the next req after SQUASH resolves normally.
- Force br_count to 2^CW-2 (CW=4 build) and resolve 3 branches -> br_count sticks at 15 and does not wrap.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// ============================================================================
// Module : branch_ctrl_if
// Brief  : ID-stage branch control bundle between decode/decision logic and
//          the branch resolution controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_ctrl_if #(
  parameter int CW = 16
);
  logic          id_valid;
  logic          id_ctrl;
  logic          opnd_busy;
  logic          take;
  logic [31:0]   target;
  logic          pipe_flush;
  logic          stall_id;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          squash_if;
  logic [CW-1:0] br_count;
  logic [CW-1:0] taken_count;
  logic          wait_timeout;

  // Decode/hazard side drives the request, the controller answers.
  modport master (
    output id_valid, id_ctrl, opnd_busy, take, target, pipe_flush,
    input  stall_id, redirect, redirect_pc, squash_if,
           br_count, taken_count, wait_timeout
  );

  modport slave (
    input  id_valid, id_ctrl, opnd_busy, take, target, pipe_flush,
    output stall_id, redirect, redirect_pc, squash_if,
           br_count, taken_count, wait_timeout
  );
endinterface

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
// Module : branch_ctrl
// Brief  : Holds ID on in-flight branch operands, resolves control transfers,
//          issues a one-cycle PC redirect/IF squash and keeps branch stats.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_ctrl #(
  parameter int CW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  branch_ctrl_if.slave  bus
);

  localparam int                  c_wait_w   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_wait_w-1:0] c_max_wait = c_wait_w'(MAX_WAIT);
  localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);
  localparam logic [CW-1:0]       c_cnt_max  = '1;
  localparam logic [CW-1:0]       c_cnt_one  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic                r_redirect;
  logic                r_squash_if;
  logic [31:0]         r_redirect_pc;
  logic [CW-1:0]       r_br_count;
  logic [CW-1:0]       r_taken_count;
  logic                r_wait_timeout;

  logic                w_req;
  logic [c_wait_w-1:0] w_wait_nxt;

  assign w_req = bus.id_valid & bus.id_ctrl;

  // Entering WAIT starts the count at 1; staying in WAIT saturates at MAX_WAIT.
  assign w_wait_nxt = (r_state != ST_WAIT)       ? c_wait_one :
                      (r_wait_cnt == c_max_wait) ? r_wait_cnt :
                                                   r_wait_cnt + c_wait_one;

  // The ID instruction seen during SQUASH is wrong-path, so it never stalls.
  assign bus.stall_id = !rst & w_req & bus.opnd_busy &
                        (r_state != ST_SQUASH) & !bus.pipe_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_wait_cnt     <= '0;
      r_redirect     <= 1'b0;
      r_squash_if    <= 1'b0;
      r_redirect_pc  <= '0;
      r_br_count     <= '0;
      r_taken_count  <= '0;
      r_wait_timeout <= 1'b0;
    end else if (bus.pipe_flush) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_redirect  <= 1'b0;
      r_squash_if <= 1'b0;
    end else begin
      r_redirect  <= 1'b0;
      r_squash_if <= 1'b0;
      case (r_state)
        ST_IDLE, ST_WAIT: begin
          if (!w_req) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
          end else if (bus.opnd_busy) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == c_max_wait) begin
              r_wait_timeout <= 1'b1;
            end
          end else begin
            r_wait_cnt <= '0;
            if (r_br_count != c_cnt_max) begin
              r_br_count <= r_br_count + c_cnt_one;
            end
            if (bus.take) begin
              if (r_taken_count != c_cnt_max) begin
                r_taken_count <= r_taken_count + c_cnt_one;
              end
              r_redirect    <= 1'b1;
              r_squash_if   <= 1'b1;
              r_redirect_pc <= bus.target;
              r_state       <= ST_SQUASH;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_SQUASH: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.redirect     = r_redirect;
  assign bus.squash_if    = r_squash_if;
  assign bus.redirect_pc  = r_redirect_pc;
  assign bus.br_count     = r_br_count;
  assign bus.taken_count  = r_taken_count;
  assign bus.wait_timeout = r_wait_timeout;

endmodule

`default_nettype wire
